// File: rtl/yarp_pkg.sv
// Shared types for the yarp core memory path.
package yarp_pkg;

  // Memory access size; 2'b10 is not a legal encoding.
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    INSTR,
    DATA
  } mem_owner_t;

  // Transaction captured at grant time; drives the bus and formats the response.
  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wdata;
    mem_access_size_t size;
    logic [1:0]       lane;
    logic             zero_extnd;
  } mem_txn_t;

endpackage

// File: rtl/yarp_mem_fmt.sv
// Store lane formatting, load extraction/extension and misalignment detection.
module yarp_mem_fmt
  import yarp_pkg::*;
(
  input  mem_access_size_t st_size_i,
  input  logic [1:0]       st_lane_i,
  input  logic [31:0]      st_wdata_i,
  output logic [3:0]       st_be_o,
  output logic [31:0]      st_wdata_o,
  output logic             misalign_o,
  input  mem_access_size_t ld_size_i,
  input  logic [1:0]       ld_lane_i,
  input  logic             ld_zero_extnd_i,
  input  logic [31:0]      ld_rdata_i,
  output logic [31:0]      ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: byte enables, lane-replicated data and alignment check.
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_wdata_i;
    misalign_o = 1'b0;
    case (st_size_i)
      BYTE: begin
        st_be_o    = 4'b0001 << st_lane_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      HALF_WORD: begin
        st_be_o    = 4'b0011 << {st_lane_i[1], 1'b0};
        st_wdata_o = {2{st_wdata_i[15:0]}};
        misalign_o = st_lane_i[0];
      end
      WORD: begin
        st_be_o    = 4'hF;
        misalign_o = |st_lane_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    ld_byte   = ld_rdata_i[8*ld_lane_i +: 8];
    ld_half   = ld_rdata_i[16*ld_lane_i[1] +: 16];
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      BYTE:      ld_data_o = {{24{ld_byte[7] & ~ld_zero_extnd_i}}, ld_byte};
      HALF_WORD: ld_data_o = {{16{ld_half[15] & ~ld_zero_extnd_i}}, ld_half};
      default:   ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/yarp_mem_arb.sv
// Arbitrates instruction fetch and load/store onto one req/gnt/rvalid memory bus.
module yarp_mem_arb
  import yarp_pkg::*;
#(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_zero_extnd_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_misalign_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  arb_state_t       state_q, state_d;
  mem_owner_t       owner_q, owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  mem_txn_t         txn_q, txn_d;
  logic             mem_req_q, mem_req_d;

  mem_access_size_t data_size;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic             misalign;
  logic [31:0]      ld_data;
  logic             data_win, instr_win, rsp_fire;
  logic             unused_instr_addr;

  assign unused_instr_addr = ^instr_addr_i[1:0];
  assign data_size         = mem_access_size_t'(data_byte_i);

  yarp_mem_fmt u_fmt (
    .st_size_i       (data_size),
    .st_lane_i       (data_addr_i[1:0]),
    .st_wdata_i      (data_wdata_i),
    .st_be_o         (st_be),
    .st_wdata_o      (st_wdata),
    .misalign_o      (misalign),
    .ld_size_i       (txn_q.size),
    .ld_lane_i       (txn_q.lane),
    .ld_zero_extnd_i (txn_q.zero_extnd),
    .ld_rdata_i      (mem_rdata_i),
    .ld_data_o       (ld_data)
  );

  // Data wins unless a waiting fetch has already seen a full burst of data grants.
  assign data_win  = data_req_i & ~(instr_req_i & (burst_cnt_q == 4'(DATA_BURST_MAX)));
  assign instr_win = ~data_win & instr_req_i;

  // Next-state, grant pulses and transaction capture.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    burst_cnt_d     = burst_cnt_q;
    txn_d           = txn_q;
    mem_req_d       = mem_req_q;
    instr_gnt_o     = 1'b0;
    data_gnt_o      = 1'b0;
    data_misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_win) begin
          data_gnt_o = 1'b1;
          if (misalign) begin
            // Rejected outright: no bus cycle, burst accounting untouched.
            data_misalign_o = 1'b1;
          end else begin
            txn_d = '{addr:       {data_addr_i[31:2], 2'b00},
                      we:         data_wr_i,
                      be:         st_be,
                      wdata:      data_wr_i ? st_wdata : 32'h0,
                      size:       data_size,
                      lane:       data_addr_i[1:0],
                      zero_extnd: data_zero_extnd_i};
            owner_d   = DATA;
            state_d   = REQ;
            mem_req_d = 1'b1;
            if (!instr_req_i)              burst_cnt_d = 4'd0;
            else if (burst_cnt_q != 4'hF)  burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else if (instr_win) begin
          instr_gnt_o = 1'b1;
          txn_d = '{addr:       {instr_addr_i[31:2], 2'b00},
                    we:         1'b0,
                    be:         4'hF,
                    wdata:      32'h0,
                    size:       WORD,
                    lane:       2'b00,
                    zero_extnd: 1'b0};
          owner_d     = INSTR;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          burst_cnt_d = 4'd0;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d   = RSP;
          mem_req_d = 1'b0;
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus-facing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      burst_cnt_q <= 4'd0;
      txn_q       <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      txn_q       <= txn_d;
      mem_req_q   <= mem_req_d;
    end
  end

  // Response routing to the owner; rvalid outside RSP is dropped.
  always_comb begin
    rsp_fire       = (state_q == RSP) & mem_rvalid_i;
    instr_rvalid_o = rsp_fire & (owner_q == INSTR);
    data_rvalid_o  = rsp_fire & (owner_q == DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o & ~txn_q.we) ? ld_data : 32'h0;
  end

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = txn_q.addr;
  assign mem_we_o    = txn_q.we;
  assign mem_be_o    = txn_q.be;
  assign mem_wdata_o = txn_q.wdata;

endmodule

// File: tb/tb_yarp_mem_arb.sv
// Directed bench for yarp_mem_arb with a simple bus responder and event monitor.
module tb_yarp_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_wr_i;
  logic [1:0]  data_byte_i;
  logic        data_zero_extnd_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_misalign_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  yarp_mem_arb #(.DATA_BURST_MAX(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_req_i       (instr_req_i),
    .instr_addr_i      (instr_addr_i),
    .instr_gnt_o       (instr_gnt_o),
    .instr_rvalid_o    (instr_rvalid_o),
    .instr_rdata_o     (instr_rdata_o),
    .data_req_i        (data_req_i),
    .data_addr_i       (data_addr_i),
    .data_wr_i         (data_wr_i),
    .data_byte_i       (data_byte_i),
    .data_zero_extnd_i (data_zero_extnd_i),
    .data_wdata_i      (data_wdata_i),
    .data_gnt_o        (data_gnt_o),
    .data_rvalid_o     (data_rvalid_o),
    .data_rdata_o      (data_rdata_o),
    .data_misalign_o   (data_misalign_o),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder controls (written by the main thread).
  int          gnt_wait  = 0;
  bit          rsp_block = 1'b0;
  logic [31:0] rsp_data  = 32'h0;
  // Responder-private state.
  int          wait_cnt  = 0;
  bit          pend      = 1'b0;
  // Monitor observations.
  int          rv_i = 0, rv_d = 0, gnt_i_cnt = 0, mis_cnt = 0;
  int          gcount = 0, req_starts = 0, req_run = 0, unstable = 0;
  int          zero_bad = 0, both_gnt = 0;
  logic [15:0] gseq = '0;
  logic [31:0] last_i = '0, last_d = '0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;
  logic        req_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus responder drives at the falling edge, monitor samples 1ns later.
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (pend && !rsp_block) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_data;
      pend         = 1'b0;
    end else if (mem_req_o && !pend) begin
      if (wait_cnt < gnt_wait) wait_cnt++;
      else begin
        mem_gnt_i = 1'b1;
        wait_cnt  = 0;
        pend      = 1'b1;
      end
    end
    #1;
    if (instr_gnt_o || data_gnt_o) begin
      gseq = {gseq[14:0], instr_gnt_o};
      gcount++;
    end
    if (instr_gnt_o) gnt_i_cnt++;
    if (instr_gnt_o && data_gnt_o) both_gnt++;
    if (data_misalign_o) mis_cnt++;
    if (instr_rvalid_o) begin rv_i++; last_i = instr_rdata_o; end
    if (data_rvalid_o)  begin rv_d++; last_d = data_rdata_o;  end
    if (!instr_rvalid_o && instr_rdata_o != 32'h0) zero_bad++;
    if (!data_rvalid_o && data_rdata_o != 32'h0) zero_bad++;
    if (mem_req_o) begin
      if (!req_prev) begin
        snap_addr = mem_addr_o; snap_be = mem_be_o; snap_we = mem_we_o; snap_wdata = mem_wdata_o;
        req_starts++;
        req_run = 1;
      end else begin
        if (mem_addr_o != snap_addr || mem_be_o != snap_be || mem_we_o != snap_we ||
            mem_wdata_o != snap_wdata) unstable++;
        req_run++;
      end
    end
    req_prev = mem_req_o;
  end

  task automatic data_txn(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                          input logic zx, input logic [31:0] wd, input bit wait_rsp);
    int n;
    int c0;
    c0 = rv_d;
    @(negedge clk);
    data_req_i = 1'b1; data_addr_i = addr; data_wr_i = wr; data_byte_i = sz;
    data_zero_extnd_i = zx; data_wdata_i = wd;
    #2;
    n = 0;
    while (!data_gnt_o && n < 20) begin @(negedge clk); #2; n++; end
    check_eq("data_gnt", {31'h0, data_gnt_o}, 32'h1);
    @(negedge clk);
    data_req_i = 1'b0;
    if (wait_rsp) begin
      #2;
      n = 0;
      while (rv_d == c0 && n < 50) begin @(negedge clk); #2; n++; end
      check_eq("data_rvalid_cnt", rv_d - c0, 32'h1);
    end
  endtask

  task automatic instr_txn(input logic [31:0] addr);
    int n;
    int c0;
    c0 = rv_i;
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = addr;
    #2;
    n = 0;
    while (!instr_gnt_o && n < 20) begin @(negedge clk); #2; n++; end
    check_eq("instr_gnt", {31'h0, instr_gnt_o}, 32'h1);
    @(negedge clk);
    instr_req_i = 1'b0;
    #2;
    n = 0;
    while (rv_i == c0 && n < 50) begin @(negedge clk); #2; n++; end
    check_eq("instr_rvalid_cnt", rv_i - c0, 32'h1);
  endtask

  // Misaligned request: gnt and misalign in the same cycle, never reaches the bus.
  task automatic misalign_try(input string tag, input logic [31:0] addr, input logic [1:0] sz);
    int s0;
    int m0;
    s0 = req_starts;
    m0 = mis_cnt;
    @(negedge clk);
    data_req_i = 1'b1; data_addr_i = addr; data_wr_i = 1'b1; data_byte_i = sz;
    data_wdata_i = 32'h1111_2222;
    #2;
    check_eq({tag, "_gnt_misalign"}, {30'h0, data_gnt_o, data_misalign_o}, 32'h3);
    @(negedge clk);
    data_req_i = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check_eq({tag, "_no_bus"}, req_starts - s0, 32'h0);
    check_eq({tag, "_pulses"}, mis_cnt - m0, 32'h1);
  endtask

  initial begin
    int n;
    int i0, d0;
    reset = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_wr_i = 1'b0; data_byte_i = 2'b00;
    data_zero_extnd_i = 1'b0; data_wdata_i = '0;
    repeat (2) @(negedge clk);
    #2;
    check_eq("reset_mem", {mem_req_o, mem_we_o, mem_be_o, 26'h0}, 32'h0);
    check_eq("reset_addr", mem_addr_o, 32'h0);
    check_eq("reset_wdata", mem_wdata_o, 32'h0);
    check_eq("reset_core", {27'h0, instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o,
                            data_misalign_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Store byte to lane 3.
    rsp_data = 32'hFFFF_FFFF;
    data_txn(32'h0000_1003, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, 1'b1);
    check_eq("sb_addr", snap_addr, 32'h0000_1000);
    check_eq("sb_be_we", {27'h0, snap_we, snap_be}, {27'h0, 1'b1, 4'b1000});
    check_eq("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
    check_eq("sb_rdata", last_d, 32'h0);

    // Load halfword, upper half, signed then zero-extended.
    rsp_data = 32'h8001_1234;
    data_txn(32'h0000_2002, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
    check_eq("lh_addr", snap_addr, 32'h0000_2000);
    check_eq("lh_be_we", {27'h0, snap_we, snap_be}, {27'h0, 1'b0, 4'b1100});
    check_eq("lh_signed", last_d, 32'hFFFF_8001);
    data_txn(32'h0000_2002, 1'b0, 2'b01, 1'b1, 32'h0, 1'b1);
    check_eq("lhu", last_d, 32'h0000_8001);

    // Load byte, lane 1, signed.
    rsp_data = 32'h0000_8000;
    data_txn(32'h0000_5001, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
    check_eq("lb_signed", last_d, 32'hFFFF_FF80);
    check_eq("lb_be", {28'h0, snap_be}, 32'h2);

    // Misaligned accesses.
    misalign_try("mis_word", 32'h0000_3001, 2'b11);
    misalign_try("mis_half", 32'h0000_3003, 2'b01);
    misalign_try("mis_size", 32'h0000_3000, 2'b10);

    // Starvation guard: both requesters held high.
    rsp_data = 32'h1234_5678;
    gcount = 0; gseq = '0;
    i0 = rv_i; d0 = rv_d;
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200;
    data_req_i = 1'b1; data_addr_i = 32'h0000_0100; data_wr_i = 1'b0; data_byte_i = 2'b11;
    data_zero_extnd_i = 1'b0;
    #2;
    n = 0;
    while (gcount < 10 && n < 300) begin @(negedge clk); #2; n++; end
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check_eq("starve_count", gcount, 32'd10);
    check_eq("starve_order", {22'h0, gseq[9:0]}, {22'h0, 10'b0000100001});
    check_eq("starve_rv_i", rv_i - i0, 32'd2);
    check_eq("starve_rv_d", rv_d - d0, 32'd8);
    check_eq("starve_irdata", last_i, 32'h1234_5678);
    check_eq("starve_drdata", last_d, 32'h1234_5678);

    // Grant wait: bus holds off gnt for 3 cycles.
    gnt_wait = 3;
    i0 = gnt_i_cnt; d0 = rv_i;
    rsp_data = 32'h0;
    data_txn(32'h0000_4002, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 1'b1);
    check_eq("gw_req_cycles", req_run, 32'd4);
    check_eq("gw_stable", unstable, 32'd0);
    check_eq("gw_addr", snap_addr, 32'h0000_4000);
    check_eq("gw_be", {28'h0, snap_be}, 32'hC);
    check_eq("gw_wdata", snap_wdata, 32'hBEEF_BEEF);
    check_eq("gw_instr_untouched", {gnt_i_cnt - i0 + rv_i - d0}, 32'h0);
    gnt_wait = 0;

    // Reset while in RSP, then a stale rvalid.
    rsp_block = 1'b1;
    d0 = rv_d;
    rsp_data = 32'hCAFE_F00D;
    data_txn(32'h0000_6000, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #2;
    check_eq("rst_rsp_mem", {mem_req_o, mem_we_o, mem_be_o, 26'h0}, 32'h0);
    check_eq("rst_rsp_addr", mem_addr_o, 32'h0);
    check_eq("rst_rsp_wdata", mem_wdata_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rsp_block = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check_eq("rst_rsp_dropped", rv_d - d0, 32'h0);
    check_eq("rst_rsp_outs", {data_rvalid_o, instr_rvalid_o, mem_req_o, 29'h0}, 32'h0);
    rsp_data = 32'h0000_0013;
    instr_txn(32'h0000_0800);
    check_eq("post_rst_addr", snap_addr, 32'h0000_0800);
    check_eq("post_rst_be", {27'h0, snap_we, snap_be}, 32'hF);
    check_eq("post_rst_irdata", last_i, 32'h0000_0013);

    check_eq("rdata_zero_when_idle", zero_bad, 32'h0);
    check_eq("single_gnt", both_gnt, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
